// File: rtl/tile_row_gen.sv
// -----------------------------------------------------------------------------
// tile_row_gen
//
// Consumer end of the PRNG seed stream. Each request builds one playfield row of
// tile colours, one candidate colour per DRAW cycle taken from the low bits of
// the free-running PRNG output. A row is legal when it has no horizontal triple
// and no column matching the previously emitted row (prev). A column that keeps
// drawing illegal candidates falls back to the lowest legal colour after
// MAX_TRIES draws, so the worst-case latency is bounded.
//
// Optional feature macro: TILE_ROW_GEN_STATS_EN
//   defined   -> reject_cnt port present: saturating count of illegal
//                candidates (fallback cycles included), cleared only by Reset.
//   undefined -> reject_cnt port and counter absent.
//
// Ports
//   Clk        in   1               system clock
//   Reset      in   1               synchronous, active-high reset
//   rand_in    in   RAND_W          PRNG output; only [COLOR_W-1:0] is used
//   req        in   1               request a new row (sampled in IDLE, and in
//                                   VALID on the handshake cycle)
//   row_ready  in   1               consumer accepts row_out
//   row_valid  out  1               row_out holds a complete legal row
//   row_out    out  COLS*COLOR_W    column i at [i*COLOR_W +: COLOR_W]
//   reject_cnt out  16              only with TILE_ROW_GEN_STATS_EN
//   busy       out  1               high in DRAW and VALID
//
// Handshake: a row transfers on any cycle where row_valid && row_ready. While
// row_valid is high and row_ready is low, row_out is held stable; row_valid
// never drops without a transfer (except on Reset).
// -----------------------------------------------------------------------------
module tile_row_gen #(
    parameter int COLS       = 6,
    parameter int COLOR_W    = 3,
    parameter int NUM_COLORS = 5,
    parameter int MAX_TRIES  = 4,
    parameter int RAND_W     = 50
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [RAND_W-1:0]       rand_in,
    input  logic                    req,
    input  logic                    row_ready,
    output logic                    row_valid,
    output logic [COLS*COLOR_W-1:0] row_out,
`ifdef TILE_ROW_GEN_STATS_EN
    output logic [15:0]             reject_cnt,
`endif
    output logic                    busy
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [COLOR_W-1:0] EMPTY        = '1;
    localparam logic [COL_W-1:0]   LAST_COL     = COL_W'(COLS - 1);
    localparam logic [TRY_W-1:0]   LAST_TRY     = TRY_W'(MAX_TRIES - 1);
    localparam logic [COLOR_W:0]   NUM_COLORS_W = (COLOR_W + 1)'(NUM_COLORS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [TRY_W-1:0]     tries_q, tries_d;
    logic [COLOR_W-1:0]   row_q  [COLS];
    logic [COLOR_W-1:0]   prev_q [COLS];

    logic [COLOR_W-1:0]   cand;
    logic [COLOR_W-1:0]   left1, left2, above;
    logic                 cand_ok;
    logic [COLOR_W-1:0]   fb_color;
    logic                 fb_found;
    logic                 wr_en;
    logic [COLOR_W-1:0]   wr_val;
    logic                 prev_ld;

    // Only the low colour bits of the PRNG word matter here.
    logic unused_rand_hi;
    assign unused_rand_hi = ^rand_in[RAND_W-1:COLOR_W];

    assign cand = rand_in[COLOR_W-1:0];

    // A colour passes when it neither completes a horizontal triple nor
    // repeats the tile directly above it in the previous row.
    function automatic logic color_ok(input logic [COLOR_W-1:0] c,
                                      input logic [COLOR_W-1:0] l1,
                                      input logic [COLOR_W-1:0] l2,
                                      input logic [COLOR_W-1:0] up);
        return !((c == l1) && (c == l2)) && (c != up);
    endfunction

    // Neighbours of the current column. Missing left neighbours read as EMPTY,
    // which no legal colour can equal, so the triple rule only fires from col 2.
    always_comb begin
        left1 = EMPTY;
        left2 = EMPTY;
        above = EMPTY;
        for (int i = 0; i < COLS; i++) begin
            if (COL_W'(i) == col_q)     above = prev_q[i];
            if (COL_W'(i + 1) == col_q) left1 = row_q[i];
            if (COL_W'(i + 2) == col_q) left2 = row_q[i];
        end
    end

    assign cand_ok = ({1'b0, cand} < NUM_COLORS_W) && color_ok(cand, left1, left2, above);

    // Lowest passing colour; one always exists for NUM_COLORS >= 3 since at
    // most two colours (left pair, above) can be excluded.
    always_comb begin
        fb_color = '0;
        fb_found = 1'b0;
        for (int k = 0; k < NUM_COLORS; k++) begin
            if (!fb_found && color_ok(COLOR_W'(k), left1, left2, above)) begin
                fb_color = COLOR_W'(k);
                fb_found = 1'b1;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        tries_d = tries_q;
        wr_en   = 1'b0;
        wr_val  = cand;
        prev_ld = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_DRAW;
                    col_d   = '0;
                    tries_d = '0;
                end
            end
            S_DRAW: begin
                if (cand_ok) begin
                    wr_en  = 1'b1;
                    wr_val = cand;
                end else if (tries_q == LAST_TRY) begin
                    wr_en  = 1'b1;
                    wr_val = fb_color;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
                if (wr_en) begin
                    tries_d = '0;
                    if (col_q == LAST_COL) begin
                        state_d = S_VALID;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_VALID: begin
                if (row_ready) begin
                    prev_ld = 1'b1;
                    col_d   = '0;
                    tries_d = '0;
                    state_d = req ? S_DRAW : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            tries_q <= '0;
            for (int i = 0; i < COLS; i++) begin
                row_q[i]  <= '0;
                prev_q[i] <= EMPTY;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            tries_q <= tries_d;
            for (int i = 0; i < COLS; i++) begin
                if (wr_en && (col_q == COL_W'(i))) row_q[i] <= wr_val;
                if (prev_ld) prev_q[i] <= row_q[i];
            end
        end
    end

    // The working row doubles as the output register: it is only complete
    // (and only advertised) in VALID, and keeps its value through IDLE.
    for (genvar g = 0; g < COLS; g++) begin : g_pack
        assign row_out[g*COLOR_W +: COLOR_W] = row_q[g];
    end

    assign row_valid = (state_q == S_VALID);
    assign busy      = (state_q != S_IDLE);

`ifdef TILE_ROW_GEN_STATS_EN
    logic reject;
    assign reject = (state_q == S_DRAW) && !cand_ok;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            reject_cnt <= '0;
        end else if (reject && (reject_cnt != 16'hFFFF)) begin
            reject_cnt <= reject_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_row_gen.sv
// -----------------------------------------------------------------------------
// tb_tile_row_gen
//
// Drives tile_row_gen with directed and random PRNG streams. A row-level model
// computes, from the legality rules, the row each request must produce, how
// many draw cycles it takes and which draws are rejects. A compare process
// checks row_valid/busy (and row_out, reject_cnt when meaningful) every cycle.
// -----------------------------------------------------------------------------
module tb_tile_row_gen;

    localparam int COLS       = 6;
    localparam int COLOR_W    = 3;
    localparam int NUM_COLORS = 5;
    localparam int MAX_TRIES  = 4;
    localparam int RAND_W     = 50;
    localparam int EMPTY      = 7;

    logic                    Clk;
    logic                    Reset;
    logic [RAND_W-1:0]       rand_in;
    logic                    req;
    logic                    row_ready;
    logic                    row_valid;
    logic [COLS*COLOR_W-1:0] row_out;
    logic                    busy;
`ifdef TILE_ROW_GEN_STATS_EN
    logic [15:0]             reject_cnt;
`endif

    tile_row_gen #(
        .COLS(COLS), .COLOR_W(COLOR_W), .NUM_COLORS(NUM_COLORS),
        .MAX_TRIES(MAX_TRIES), .RAND_W(RAND_W)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .rand_in(rand_in),
        .req(req),
        .row_ready(row_ready),
        .row_valid(row_valid),
        .row_out(row_out),
`ifdef TILE_ROW_GEN_STATS_EN
        .reject_cnt(reject_cnt),
`endif
        .busy(busy)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic                    check_en  = 1'b0;
    logic                    exp_valid = 1'b0;
    logic                    exp_busy  = 1'b0;
    logic [COLS*COLOR_W-1:0] exp_row   = '0;
    int                      exp_rej   = 0;

    logic [COLS*COLOR_W-1:0] exp_q[$];   // rows still to be delivered
    int  prev_m [COLS];
    int  m_row  [COLS];
    int  rand_q[$];
    bit  rej_q[$];
    int  last_n;
    bit  in_draw = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit legal(int v, int c);
        if (v >= NUM_COLORS) return 1'b0;
        if (c >= 2) begin
            if (v == m_row[c-1] && v == m_row[c-2]) return 1'b0;
        end
        if (v == prev_m[c]) return 1'b0;
        return 1'b1;
    endfunction

    // Consumes rand_q in order: returns the finished row, number of draws,
    // and per-draw reject flags in rej_q.
    task automatic model_row(output logic [COLS*COLOR_W-1:0] r, output int n);
        int idx = 0;
        n = 0;
        rej_q.delete();
        for (int c = 0; c < COLS; c++) m_row[c] = EMPTY;
        for (int c = 0; c < COLS; c++) begin
            int t = 0;
            bit done = 1'b0;
            while (!done) begin
                int v = rand_q[idx];
                idx++;
                n++;
                if (legal(v, c)) begin
                    m_row[c] = v;
                    rej_q.push_back(1'b0);
                    done = 1'b1;
                end else begin
                    rej_q.push_back(1'b1);
                    if (t == MAX_TRIES - 1) begin
                        bit found = 1'b0;
                        for (int k = 0; k < NUM_COLORS; k++) begin
                            if (!found && legal(k, c)) begin
                                m_row[c] = k;
                                found = 1'b1;
                            end
                        end
                        done = 1'b1;
                    end else begin
                        t++;
                    end
                end
            end
        end
        r = '0;
        for (int c = 0; c < COLS; c++) r[c*COLOR_W +: COLOR_W] = m_row[c][COLOR_W-1:0];
    endtask

    // ---------------- compare process ----------------
    always @(negedge Clk) begin
        if (check_en) begin
            chk("row_valid", {31'd0, row_valid}, {31'd0, exp_valid});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (exp_valid) chk("row_out", {14'd0, row_out}, {14'd0, exp_row});
`ifdef TILE_ROW_GEN_STATS_EN
            chk("reject_cnt", {16'd0, reject_cnt}, exp_rej);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [RAND_W-1:0] rnd_word(input int low);
        logic [63:0] r64;
        r64 = {$urandom, $urandom};
        return {r64[RAND_W-1-COLOR_W:0], 3'(low)};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic after_reset();
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_rej   = 0;
        in_draw   = 1'b0;
        exp_q.delete();
        for (int c = 0; c < COLS; c++) prev_m[c] = EMPTY;
        chk("reset_row_out", {14'd0, row_out}, 32'd0);
        chk("reset_row_valid", {31'd0, row_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        req   = 1'b0;
        step();
        Reset = 1'b0;
        after_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            req       = 1'b0;
            rand_in   = rnd_word($urandom_range(0, 7));
            row_ready = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    // mode 0: random colour stream, mode 1: colour 'val' held.
    // abort_at >= 0 asserts Reset during that draw cycle.
    task automatic do_draw(input int mode, input int val, input int abort_at);
        logic [COLS*COLOR_W-1:0] r;
        int n;
        rand_q.delete();
        for (int i = 0; i < COLS * MAX_TRIES; i++)
            rand_q.push_back(mode == 0 ? int'($urandom_range(0, 7)) : val);
        model_row(r, n);
        if (!in_draw) begin
            req       = 1'b1;
            rand_in   = rnd_word($urandom_range(0, 7));
            row_ready = 1'($urandom_range(0, 1));
            step();
            exp_busy  = 1'b1;
            exp_valid = 1'b0;
            in_draw   = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            rand_in   = rnd_word(rand_q[i]);
            req       = 1'($urandom_range(0, 1));
            row_ready = 1'($urandom_range(0, 1));
            if (i == abort_at) begin
                Reset = 1'b1;
                step();
                Reset = 1'b0;
                req   = 1'b0;
                after_reset();
                return;
            end
            step();
            if (rej_q[i] && exp_rej < 65535) exp_rej++;
            if (i == n - 1) begin
                exp_valid = 1'b1;
                exp_row   = r;
            end
        end
        req     = 1'b0;
        in_draw = 1'b0;
        last_n  = n;
        exp_q.push_back(r);
    endtask

    task automatic do_valid(input int stall, input bit chain, input bit force_req);
        logic [COLS*COLOR_W-1:0] r;
        for (int s = 0; s < stall; s++) begin
            row_ready = 1'b0;
            req       = force_req ? 1'b1 : 1'($urandom_range(0, 1));
            rand_in   = rnd_word($urandom_range(0, 7));
            step();
        end
        row_ready = 1'b1;
        req       = chain;
        step();
        row_ready = 1'b0;
        req       = 1'b0;
        r = exp_q.pop_front();
        for (int c = 0; c < COLS; c++) prev_m[c] = int'(r[c*COLOR_W +: COLOR_W]);
        exp_valid = 1'b0;
        exp_busy  = chain;
        in_draw   = chain;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [COLS*COLOR_W-1:0] row_t1, row_t2, row_t3;
        row_t1 = {3'd0, 3'd2, 3'd2, 3'd0, 3'd2, 3'd2};
        row_t2 = {3'd2, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0};
        row_t3 = {3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};

        Reset     = 1'b1;
        req       = 1'b0;
        row_ready = 1'b0;
        rand_in   = '0;
        step();
        step();
        Reset = 1'b0;
        after_reset();
        check_en = 1'b1;

        // Colour 2 held from empty history.
        do_draw(1, 2, -1);
        chk("t1_draws", last_n, 32'd12);
        chk("t1_row", {14'd0, row_out}, {14'd0, row_t1});
`ifdef TILE_ROW_GEN_STATS_EN
        chk("t1_reject_cnt", {16'd0, reject_cnt}, 32'd8);
`endif
        do_valid(0, 1'b0, 1'b0);
        idle(1);

        // Same stream against the row just emitted.
        do_draw(1, 2, -1);
        chk("t2_draws", last_n, 32'd18);
        chk("t2_row", {14'd0, row_out}, {14'd0, row_t2});
        do_valid(0, 1'b0, 1'b0);

        // Out-of-range colour held: every column falls back.
        reset_dut();
        do_draw(1, 6, -1);
        chk("t3_draws", last_n, 32'd24);
        chk("t3_row", {14'd0, row_out}, {14'd0, row_t3});

        // Stall with req pulsed, then one handshake.
        do_valid(5, 1'b0, 1'b1);
        chk("t4_valid_drop", {31'd0, row_valid}, 32'd0);
        idle(3);
        chk("t4_no_second_row", {31'd0, busy}, 32'd0);

        // Reset while drawing column 3.
        do_draw(1, 2, 6);
        idle(1);
        do_draw(1, 2, -1);
        chk("t5_row", {14'd0, row_out}, {14'd0, row_t1});
        do_valid(0, 1'b0, 1'b0);

        // Random streams, random stalls, back-to-back requests.
        for (int it = 0; it < 40; it++) begin
            do_draw(0, 0, -1);
            do_valid($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
            if (!in_draw) idle($urandom_range(0, 2));
        end
        if (in_draw) begin
            do_draw(0, 0, -1);
            do_valid(0, 1'b0, 1'b0);
        end

`ifdef TILE_ROW_GEN_STATS_EN
        begin
            int forced = 0;
            reset_dut();
            while (forced < 70000) begin
                do_draw(1, 6, -1);
                forced += last_n;
                do_valid(0, 1'b1, 1'b0);
            end
            do_draw(1, 6, -1);
            do_valid(0, 1'b0, 1'b0);
            chk("t6_reject_sat", {16'd0, reject_cnt}, 32'h0000FFFF);
        end
`endif

        idle(2);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
